packet_requester: RTL and testbench

- Per-port initiator that sits between a local flit source and one request/grant lane of the 5-port router arbiter.
- Buffers incoming flits and raises req toward the arbiter when a complete header is at the buffer head.
- Drives flit_id and length so the arbiter timer loads on the header flit, then streams the packet while grant is held.
- Releases req after the tail flit; handles preemption when grant drops on arbiter timeout.

---
 rtl/packet_requester_if.sv | 28 ++
 rtl/packet_requester.sv | 222 ++++++++++++++++++++++
 tb/tb_packet_requester.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_requester_if.sv
// Flit source handshake plus the request/grant lane toward the 5-port router arbiter.
interface packet_requester_if #(
   parameter int unsigned DATA_W = 32
) ();
   logic              src_valid;
   logic              src_ready;
   logic              src_sop;
   logic [DATA_W-1:0] src_data;
   logic [11:0]       src_len;
   logic              grant;
   logic              req;
   logic [2:0]        flit_id;
   logic [11:0]       length;
   logic              flit_valid;
   logic [DATA_W-1:0] flit_data;
   logic              preempt;
   logic              starve;

   modport master (
      input  src_valid, src_sop, src_data, src_len, grant,
      output src_ready, req, flit_id, length, flit_valid, flit_data, preempt, starve
   );

   modport slave (
      output src_valid, src_sop, src_data, src_len, grant,
      input  src_ready, req, flit_id, length, flit_valid, flit_data, preempt, starve
   );
endinterface

// File: rtl/packet_requester.sv
// Per-port packet initiator: buffers source flits, requests the arbiter, streams packets on grant.
// Optional grant-wait starvation watchdog enabled by defining REQ_WATCHDOG_EN.
module packet_requester #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned WD_LIMIT = 1024
) (
   input  logic               clk,
   input  logic               rst,
   packet_requester_if.master bus
);
   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned LW  = 12;
   localparam int unsigned WDW = 16;

   localparam logic [2:0] ID_IDLE   = 3'b000;
   localparam logic [2:0] ID_HEAD   = 3'b001;
   localparam logic [2:0] ID_BODY   = 3'b010;
   localparam logic [2:0] ID_TAIL   = 3'b100;
   localparam logic [2:0] ID_SINGLE = 3'b101;

   typedef struct packed {
      logic              sop;
      logic [LW-1:0]     len;
      logic [DATA_W-1:0] data;
   } entry_t;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SEND, ST_GAP} state_t;

   state_t            state_q, state_d;
   entry_t            mem_q [DEPTH];
   entry_t            wr_entry;
   entry_t            head;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              src_ready_q, src_ready_d;
   logic              in_open_q, in_open_d;
   logic [LW-1:0]     in_rem_q, in_rem_d;
   logic [LW-1:0]     wr_len;
   logic              wr_en, rd_en, empty;
   logic              req_q, req_d;
   logic              flit_valid_q, flit_valid_d;
   logic [2:0]        flit_id_q, flit_id_d;
   logic [LW-1:0]     length_q, length_d;
   logic [DATA_W-1:0] flit_data_q, flit_data_d;
   logic              preempt_q, preempt_d;
   logic [LW-1:0]     rem_q, rem_d;
   logic              first_q, first_d;

   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // Input side: length-0 headers count as one flit; orphan body flits are discarded.
   always_comb begin
      wr_en     = 1'b0;
      in_open_d = in_open_q;
      in_rem_d  = in_rem_q;
      wr_len    = (bus.src_len == '0) ? LW'(1) : bus.src_len;
      wr_entry  = '{sop: bus.src_sop, len: wr_len, data: bus.src_data};
      if (bus.src_valid && src_ready_q) begin
         if (bus.src_sop) begin
            wr_en     = 1'b1;
            in_rem_d  = wr_len - LW'(1);
            in_open_d = (wr_len != LW'(1));
         end else if (in_open_q) begin
            wr_en     = 1'b1;
            in_rem_d  = in_rem_q - LW'(1);
            in_open_d = (in_rem_q != LW'(1));
         end
      end
   end

   always_comb begin
      wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d    = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d     = count_q + CW'(wr_en) - CW'(rd_en);
      src_ready_d = (count_d != CW'(DEPTH));
   end

   // Request/stream state machine; every output is registered from its _d value.
   always_comb begin
      state_d      = state_q;
      rd_en        = 1'b0;
      req_d        = req_q;
      flit_valid_d = 1'b0;
      flit_id_d    = flit_id_q;
      length_d     = length_q;
      flit_data_d  = flit_data_q;
      preempt_d    = 1'b0;
      rem_d        = rem_q;
      first_d      = first_q;
      unique case (state_q)
         ST_IDLE: begin
            req_d = 1'b0;
            if (!empty) begin
               if (head.sop) begin
                  state_d  = ST_REQ;
                  req_d    = 1'b1;
                  length_d = head.len;
                  rem_d    = head.len;
                  first_d  = 1'b1;
               end else begin
                  rd_en = 1'b1;  // stale body left behind by a truncated packet
               end
            end
         end
         ST_REQ: begin
            req_d = 1'b1;
            if (bus.grant) state_d = ST_SEND;
         end
         ST_SEND: begin
            req_d = 1'b1;
            if (!bus.grant) begin
               preempt_d = 1'b1;
               first_d   = 1'b1;
               state_d   = ST_REQ;
            end else if (!empty) begin
               rd_en        = 1'b1;
               flit_valid_d = 1'b1;
               flit_data_d  = head.data;
               first_d      = 1'b0;
               if (rem_q != '0) rem_d = rem_q - LW'(1);
               // A (re)started burst announces the flits still owed so the arbiter timer reloads.
               if (first_q) begin
                  length_d  = rem_q;
                  flit_id_d = (rem_q == LW'(1)) ? ID_SINGLE : ID_HEAD;
               end else begin
                  flit_id_d = (rem_q == LW'(1)) ? ID_TAIL : ID_BODY;
               end
               if (rem_q <= LW'(1)) state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            req_d     = 1'b0;
            flit_id_d = ID_IDLE;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         src_ready_q  <= 1'b0;
         in_open_q    <= 1'b0;
         in_rem_q     <= '0;
         req_q        <= 1'b0;
         flit_valid_q <= 1'b0;
         flit_id_q    <= ID_IDLE;
         length_q     <= '0;
         flit_data_q  <= '0;
         preempt_q    <= 1'b0;
         rem_q        <= '0;
         first_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         src_ready_q  <= src_ready_d;
         in_open_q    <= in_open_d;
         in_rem_q     <= in_rem_d;
         req_q        <= req_d;
         flit_valid_q <= flit_valid_d;
         flit_id_q    <= flit_id_d;
         length_q     <= length_d;
         flit_data_q  <= flit_data_d;
         preempt_q    <= preempt_d;
         rem_q        <= rem_d;
         first_q      <= first_d;
      end
   end

`ifdef REQ_WATCHDOG_EN
   logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
   logic           starve_q, starve_d;

   // Counts consecutive ungranted cycles in REQ; the starvation flag is sticky until reset.
   always_comb begin
      wd_cnt_d = '0;
      starve_d = starve_q;
      if (state_q == ST_REQ && !bus.grant) begin
         wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + WDW'(1);
      end
      if (wd_cnt_d >= WDW'(WD_LIMIT)) starve_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt_q <= '0;
         starve_q <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         starve_q <= starve_d;
      end
   end

   assign bus.starve = starve_q;
`else
   logic unused_wd_limit;
   assign unused_wd_limit = ^(32'(WD_LIMIT));
   assign bus.starve      = 1'b0;
`endif

   assign bus.src_ready  = src_ready_q;
   assign bus.req        = req_q;
   assign bus.flit_id    = flit_id_q;
   assign bus.length     = length_q;
   assign bus.flit_valid = flit_valid_q;
   assign bus.flit_data  = flit_data_q;
   assign bus.preempt    = preempt_q;
endmodule

// File: tb/tb_packet_requester.sv
// Self-checking bench for packet_requester: directed vector table, corner sequences, random scoreboard.
module tb_packet_requester;
   logic clk;
   logic rst;

   packet_requester_if #(.DATA_W(32)) bus ();

   packet_requester #(.DATA_W(32), .DEPTH(8), .WD_LIMIT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef REQ_WATCHDOG_EN
   localparam logic EXP_STARVE = 1'b1;
`else
   localparam logic EXP_STARVE = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0]      len_in;
      int               nflits;
      logic [11:0]      exp_len;
      logic [4:0][2:0]  exp_id;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      int          rem;
   } exp_t;

   vec_t  vec [5];
   exp_t  expq [$];
   exp_t  e;
   bit    acc, pres, g, first_m;
   logic        pres_sop;
   logic [11:0] pres_len;
   logic [31:0] pres_data;
   int    gen_left, src_rem_m, stored, popped, lm, cnt, pcnt;
   logic [2:0] eid;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic sop, input logic [11:0] len, input logic [31:0] data,
                       output bit accepted);
      bus.src_valid = 1'b1;
      bus.src_sop   = sop;
      bus.src_len   = len;
      bus.src_data  = data;
      accepted      = bus.src_ready;
      step();
      bus.src_valid = 1'b0;
      bus.src_sop   = 1'b0;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!bus.req && n < 20) begin
         step();
         n++;
      end
      chk(name, 32'(bus.req), 32'd1);
   endtask

   task automatic expect_flit(input string name, input logic [2:0] id, input logic [11:0] len,
                              input logic [31:0] data);
      int n = 0;
      do begin
         step();
         n++;
      end while (!bus.flit_valid && n < 12);
      if (!bus.flit_valid) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout act=no_flit exp=flit", name);
      end else begin
         chk({name, "_id"}, 32'(bus.flit_id), 32'(id));
         chk({name, "_len"}, 32'(bus.length), 32'(len));
         chk({name, "_data"}, bus.flit_data, data);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   initial begin
      rst = 1'b0;
      bus.src_valid = 1'b0;
      bus.src_sop   = 1'b0;
      bus.src_len   = '0;
      bus.src_data  = '0;
      bus.grant     = 1'b0;

      // Reset values while held in reset, then ready after release
      #2;
      chk("rst_req", 32'(bus.req), 32'd0);
      chk("rst_src_ready", 32'(bus.src_ready), 32'd0);
      chk("rst_flit_valid", 32'(bus.flit_valid), 32'd0);
      chk("rst_flit_id", 32'(bus.flit_id), 32'd0);
      chk("rst_length", 32'(bus.length), 32'd0);
      chk("rst_flit_data", bus.flit_data, 32'd0);
      chk("rst_preempt", 32'(bus.preempt), 32'd0);
      chk("rst_starve", 32'(bus.starve), 32'd0);
      step();
      step();
      rst = 1'b1;
      step();
      chk("post_rst_src_ready", 32'(bus.src_ready), 32'd1);
      chk("post_rst_req", 32'(bus.req), 32'd0);

      // Single-packet vector table
      vec[0].len_in = 12'd3; vec[0].nflits = 3; vec[0].exp_len = 12'd3;
      vec[0].exp_id[0] = 3'b001; vec[0].exp_id[1] = 3'b010; vec[0].exp_id[2] = 3'b100;
      vec[1].len_in = 12'd1; vec[1].nflits = 1; vec[1].exp_len = 12'd1;
      vec[1].exp_id[0] = 3'b101;
      vec[2].len_in = 12'd0; vec[2].nflits = 1; vec[2].exp_len = 12'd1;
      vec[2].exp_id[0] = 3'b101;
      vec[3].len_in = 12'd2; vec[3].nflits = 2; vec[3].exp_len = 12'd2;
      vec[3].exp_id[0] = 3'b001; vec[3].exp_id[1] = 3'b100;
      vec[4].len_in = 12'd5; vec[4].nflits = 5; vec[4].exp_len = 12'd5;
      vec[4].exp_id[0] = 3'b001; vec[4].exp_id[1] = 3'b010; vec[4].exp_id[2] = 3'b010;
      vec[4].exp_id[3] = 3'b010; vec[4].exp_id[4] = 3'b100;

      for (int i = 0; i < 5; i++) begin
         bus.grant = 1'b0;
         for (int j = 0; j < vec[i].nflits; j++)
            push(j == 0, (j == 0) ? vec[i].len_in : 12'd0, 32'hA000_0000 + 32'(i * 16 + j), acc);
         wait_req($sformatf("vec%0d_req", i));
         bus.grant = 1'b1;
         for (int j = 0; j < vec[i].nflits; j++)
            expect_flit($sformatf("vec%0d_f%0d", i, j), vec[i].exp_id[j], vec[i].exp_len,
                        32'hA000_0000 + 32'(i * 16 + j));
         bus.grant = 1'b0;
         step();
         chk($sformatf("vec%0d_req_after_tail", i), 32'(bus.req), 32'd0);
         chk($sformatf("vec%0d_id_idle", i), 32'(bus.flit_id), 32'd0);
         chk($sformatf("vec%0d_valid_idle", i), 32'(bus.flit_valid), 32'd0);
      end

      // Back-to-back packets: req drops for exactly one cycle between them
      push(1'b1, 12'd2, 32'hB000_0000, acc);
      push(1'b0, 12'd0, 32'hB000_0001, acc);
      push(1'b1, 12'd1, 32'hB000_0002, acc);
      wait_req("b2b_req");
      bus.grant = 1'b1;
      expect_flit("b2b_a0", 3'b001, 12'd2, 32'hB000_0000);
      expect_flit("b2b_a1", 3'b100, 12'd2, 32'hB000_0001);
      cnt = 0;
      for (int n = 0; n < 10; n++) begin
         step();
         if (bus.req) break;
         cnt++;
      end
      chk("b2b_req_gap_cycles", 32'(cnt), 32'd1);
      expect_flit("b2b_b0", 3'b101, 12'd1, 32'hB000_0002);
      bus.grant = 1'b0;
      step();

      // Preemption after two flits, then resume with reloaded length
      for (int j = 0; j < 5; j++)
         push(j == 0, (j == 0) ? 12'd5 : 12'd0, 32'hC000_0000 + 32'(j), acc);
      wait_req("pre_req");
      bus.grant = 1'b1;
      expect_flit("pre_f0", 3'b001, 12'd5, 32'hC000_0000);
      expect_flit("pre_f1", 3'b010, 12'd5, 32'hC000_0001);
      bus.grant = 1'b0;
      pcnt = 0;
      cnt = 0;
      for (int n = 0; n < 4; n++) begin
         step();
         pcnt += int'(bus.preempt);
         cnt  += int'(bus.req) + int'(!bus.flit_valid);
      end
      chk("pre_pulse_count", 32'(pcnt), 32'd1);
      chk("pre_req_held_no_flit", 32'(cnt), 32'd8);
      bus.grant = 1'b1;
      expect_flit("pre_r0", 3'b001, 12'd3, 32'hC000_0002);
      expect_flit("pre_r1", 3'b010, 12'd3, 32'hC000_0003);
      expect_flit("pre_r2", 3'b100, 12'd3, 32'hC000_0004);
      bus.grant = 1'b0;
      step();

      // Full buffer: 9th flit refused; then a source stall mid-packet
      cnt = 0;
      for (int j = 0; j < 8; j++) begin
         push(j == 0, (j == 0) ? 12'd9 : 12'd0, 32'hD000_0000 + 32'(j), acc);
         cnt += int'(acc);
      end
      chk("full_accepted", 32'(cnt), 32'd8);
      chk("full_src_ready", 32'(bus.src_ready), 32'd0);
      push(1'b0, 12'd0, 32'hD000_0008, acc);
      chk("full_ninth_refused", 32'(acc), 32'd0);
      wait_req("full_req");
      bus.grant = 1'b1;
      expect_flit("full_f0", 3'b001, 12'd9, 32'hD000_0000);
      for (int j = 1; j < 8; j++)
         expect_flit($sformatf("full_f%0d", j), 3'b010, 12'd9, 32'hD000_0000 + 32'(j));
      for (int n = 0; n < 3; n++) begin
         step();
         chk($sformatf("stall%0d_valid", n), 32'(bus.flit_valid), 32'd0);
         chk($sformatf("stall%0d_req", n), 32'(bus.req), 32'd1);
         chk($sformatf("stall%0d_preempt", n), 32'(bus.preempt), 32'd0);
      end
      push(1'b0, 12'd0, 32'hD000_0008, acc);
      expect_flit("full_tail", 3'b100, 12'd9, 32'hD000_0008);
      bus.grant = 1'b0;
      step();

      // Orphan body flit is dropped
      push(1'b0, 12'd0, 32'hE000_0000, acc);
      chk("drop_accepted_handshake", 32'(acc), 32'd1);
      cnt = 0;
      for (int n = 0; n < 4; n++) begin
         step();
         cnt += int'(bus.req);
      end
      chk("drop_no_req", 32'(cnt), 32'd0);
      push(1'b1, 12'd1, 32'hE000_0001, acc);
      wait_req("drop_req");
      bus.grant = 1'b1;
      expect_flit("drop_next", 3'b101, 12'd1, 32'hE000_0001);
      bus.grant = 1'b0;
      step();

      // Randomized traffic against a packet-level scoreboard
      apply_reset();
      expq.delete();
      pres = 0; gen_left = 0; src_rem_m = 0; stored = 0; popped = 0; first_m = 1;
      pres_sop = 0; pres_len = '0; pres_data = '0;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         if (cyc >= 3000 && !pres && expq.size() == 0) break;
         if (!pres && cyc < 3000 && $urandom_range(0, 99) < 70) begin
            pres      = 1;
            pres_data = $urandom;
            if (gen_left == 0) begin
               if ($urandom_range(0, 9) == 0) begin
                  pres_sop = 1'b0;
                  pres_len = 12'($urandom);
               end else begin
                  pres_sop = 1'b1;
                  pres_len = 12'($urandom_range(0, 6));
                  gen_left = (pres_len == 0) ? 0 : int'(pres_len) - 1;
               end
            end else begin
               pres_sop = 1'b0;
               pres_len = 12'($urandom);
               gen_left--;
            end
         end
         bus.src_valid = pres;
         bus.src_sop   = pres_sop;
         bus.src_len   = pres_len;
         bus.src_data  = pres_data;
         acc           = pres && bus.src_ready;
         bus.grant     = ($urandom_range(0, 99) < 75);
         g             = bus.grant;
         step();
         if (acc) begin
            if (pres_sop) begin
               lm = (pres_len == 0) ? 1 : int'(pres_len);
               expq.push_back('{pres_data, lm});
               src_rem_m = lm - 1;
               stored++;
            end else if (src_rem_m > 0) begin
               expq.push_back('{pres_data, src_rem_m});
               src_rem_m--;
               stored++;
            end
            pres = 0;
         end
         if (!g) first_m = 1;
         if (bus.flit_valid) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rnd_unexpected_flit act=%0h exp=none", bus.flit_data);
            end else begin
               e = expq.pop_front();
               popped++;
               if (first_m) eid = (e.rem == 1) ? 3'b101 : 3'b001;
               else         eid = (e.rem == 1) ? 3'b100 : 3'b010;
               chk("rnd_data", bus.flit_data, e.data);
               chk("rnd_id", 32'(bus.flit_id), 32'(eid));
               if (first_m) chk("rnd_len", 32'(bus.length), 32'(e.rem));
               first_m = (e.rem == 1);
            end
         end
         chk("rnd_src_ready", 32'(bus.src_ready), 32'((stored - popped) < 8));
      end
      bus.src_valid = 1'b0;
      bus.grant     = 1'b0;
      chk("rnd_drained", 32'(expq.size()), 32'd0);

      // Asynchronous reset mid-packet
      apply_reset();
      for (int j = 0; j < 4; j++)
         push(j == 0, (j == 0) ? 12'd4 : 12'd0, 32'hF000_0000 + 32'(j), acc);
      wait_req("mrst_req");
      bus.grant = 1'b1;
      expect_flit("mrst_f0", 3'b001, 12'd4, 32'hF000_0000);
      #2;
      rst = 1'b0;
      #1;
      chk("mrst_req", 32'(bus.req), 32'd0);
      chk("mrst_valid", 32'(bus.flit_valid), 32'd0);
      chk("mrst_id", 32'(bus.flit_id), 32'd0);
      chk("mrst_len", 32'(bus.length), 32'd0);
      chk("mrst_data", bus.flit_data, 32'd0);
      chk("mrst_src_ready", 32'(bus.src_ready), 32'd0);
      step();
      rst = 1'b1;
      step();
      chk("mrst_post_src_ready", 32'(bus.src_ready), 32'd1);
      cnt = 0;
      for (int n = 0; n < 5; n++) begin
         step();
         cnt += int'(bus.req) + int'(bus.flit_valid);
      end
      chk("mrst_buffer_empty", 32'(cnt), 32'd0);
      bus.grant = 1'b0;

      // Grant-wait watchdog
      push(1'b1, 12'd1, 32'h5A5A_0001, acc);
      wait_req("wd_req");
      for (int n = 0; n < 15; n++) step();
      chk("wd_before_limit", 32'(bus.starve), 32'd0);
      step();
      chk("wd_at_limit", 32'(bus.starve), 32'(EXP_STARVE));
      bus.grant = 1'b1;
      expect_flit("wd_flit", 3'b101, 12'd1, 32'h5A5A_0001);
      bus.grant = 1'b0;
      step();
      chk("wd_sticky", 32'(bus.starve), 32'(EXP_STARVE));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
